cordic_seq_ctrl: RTL and testbench

// - Sequencer for the iterative CORDIC datapath: accepts a job, pulses operand load, steps the

---
 rtl/cordic_seq_ctrl_pkg.sv | 17 +
 rtl/cordic_seq_ctrl_cntr.sv | 18 +
 rtl/cordic_seq_ctrl.sv | 103 ++++++++++
 tb/tb_cordic_seq_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cordic_seq_ctrl_pkg.sv
// Shared encodings for the CORDIC sequencer: FSM states, mode values, default sizing.
package cordic_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    localparam int DEF_RNDW    = 4;
    localparam int DEF_NROUNDS = 16;

endpackage

// File: rtl/cordic_seq_ctrl_cntr.sv
// Round counter for the CORDIC sequencer; increment wins over clear.
module cntr #(
    parameter int rndw = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            c_up,
    output logic [rndw-1:0] q
);

    always_ff @(posedge clk) begin
        if (c_up)
            q <= q + rndw'(1);
        else if (clr)
            q <= '0;
    end

endmodule

// File: rtl/cordic_seq_ctrl.sv
// Job sequencer for the iterative CORDIC datapath: accept, load, NROUNDS micro-rotations,
// then hold the result until the consumer takes it.
module cordic_seq_ctrl
    import cordic_seq_ctrl_pkg::*;
#(
    parameter int RNDW    = DEF_RNDW,
    parameter int NROUNDS = DEF_NROUNDS
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            start_vld,
    output logic            start_rdy,
    input  logic            mode_in,
    input  logic            abort,
    output logic            ld,
    output logic            it_en,
    output logic [RNDW-1:0] rnd,
    output logic            mode,
    output logic            out_vld,
    input  logic            out_rdy
);

    if (NROUNDS < 1 || NROUNDS > (1 << RNDW)) begin : g_bad_nrounds
        $error("cordic_seq_ctrl: NROUNDS must be in 1..2**RNDW");
    end

    localparam logic [RNDW-1:0] LAST = RNDW'(NROUNDS - 1);

    state_t state, state_nxt;
    logic   c_clr, c_up;

    cntr #(.rndw(RNDW)) u_cntr (
        .clk  (clk),
        .clr  (c_clr),
        .c_up (c_up),
        .q    (rnd)
    );

    always_ff @(posedge clk) begin
        if (clr)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (clr)
            mode <= MODE_ROT;
        else if (state == S_IDLE && start_vld)
            mode <= mode_in;
    end

    always_comb begin
        state_nxt = state;
        start_rdy = 1'b0;
        ld        = 1'b0;
        it_en     = 1'b0;
        out_vld   = 1'b0;
        c_up      = 1'b0;
        c_clr     = 1'b0;
        case (state)
            S_IDLE: begin
                start_rdy = 1'b1;
                if (start_vld) begin
                    state_nxt = S_LOAD;
                    c_clr     = 1'b1;
                end
            end
            S_LOAD: begin
                ld        = 1'b1;
                state_nxt = S_ITER;
            end
            S_ITER: begin
                it_en = 1'b1;
                c_up  = 1'b1;
                if (rnd == LAST)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                out_vld = 1'b1;
                if (out_rdy)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort drops the job; the counter must never see up and clear together.
        if (abort && state != S_IDLE) begin
            state_nxt = S_IDLE;
            c_up      = 1'b0;
            c_clr     = 1'b1;
        end
        if (clr) begin
            state_nxt = S_IDLE;
            c_up      = 1'b0;
            c_clr     = 1'b1;
            start_rdy = 1'b0;
            ld        = 1'b0;
            it_en     = 1'b0;
            out_vld   = 1'b0;
        end
    end

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: two instances (NROUNDS=16 and NROUNDS=1) share stimulus and are
// checked every cycle against a job-age reference model.
module tb_cordic_seq_ctrl;

    localparam int NDUT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr, start_vld, mode_in, abort, out_rdy;
    logic [NDUT-1:0]      start_rdy, ld, it_en, mode, out_vld;
    logic [NDUT-1:0][3:0] rnd;

    cordic_seq_ctrl #(.RNDW(4), .NROUNDS(16)) u_d16 (
        .clk(clk), .clr(clr), .start_vld(start_vld), .start_rdy(start_rdy[0]),
        .mode_in(mode_in), .abort(abort), .ld(ld[0]), .it_en(it_en[0]), .rnd(rnd[0]),
        .mode(mode[0]), .out_vld(out_vld[0]), .out_rdy(out_rdy)
    );

    cordic_seq_ctrl #(.RNDW(4), .NROUNDS(1)) u_d1 (
        .clk(clk), .clr(clr), .start_vld(start_vld), .start_rdy(start_rdy[1]),
        .mode_in(mode_in), .abort(abort), .ld(ld[1]), .it_en(it_en[1]), .rnd(rnd[1]),
        .mode(mode[1]), .out_vld(out_vld[1]), .out_rdy(out_rdy)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc_n  = 0;

    // Reference: age = cycles since the accepting edge (-1 when idle).
    // age 1 = load, 2..N+1 = rounds 0..N-1, >= N+2 = result held.
    int   age   [NDUT];
    logic m_mode[NDUT];
    int   ridle [NDUT];

    function automatic int nr(int i);
        return (i == 0) ? 16 : 1;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    endtask

    task automatic model_edge(input int i);
        int n;
        n = nr(i);
        if (clr) begin
            age[i] = -1; ridle[i] = 0; m_mode[i] = 1'b0;
        end else if (age[i] < 0) begin
            if (start_vld) begin
                age[i] = 1; m_mode[i] = mode_in;
            end
        end else if (abort) begin
            age[i] = -1; ridle[i] = 0;
        end else if (age[i] >= n + 2) begin
            if (out_rdy) begin
                age[i] = -1; ridle[i] = n % 16;
            end
        end else begin
            age[i]++;
        end
    endtask

    task automatic check_outputs(input int i);
        int n, a, e_rnd;
        n = nr(i);
        a = age[i];
        if (a < 0)           e_rnd = ridle[i];
        else if (a >= n + 2) e_rnd = n % 16;
        else if (a >= 2)     e_rnd = a - 2;
        else                 e_rnd = 0;
        chk($sformatf("d%0d.start_rdy", i), int'(start_rdy[i]), int'(a < 0 && !clr));
        chk($sformatf("d%0d.ld", i),        int'(ld[i]),        int'(a == 1));
        chk($sformatf("d%0d.it_en", i),     int'(it_en[i]),     int'(a >= 2 && a <= n + 1));
        chk($sformatf("d%0d.out_vld", i),   int'(out_vld[i]),   int'(a >= n + 2));
        chk($sformatf("d%0d.rnd", i),       int'(rnd[i]),       e_rnd);
        chk($sformatf("d%0d.mode", i),      int'(mode[i]),      int'(m_mode[i]));
        chk($sformatf("d%0d.excl", i),      int'(ld[i]) + int'(it_en[i]) + int'(out_vld[i]) <= 1 ? 1 : 0, 1);
    endtask

    task automatic step();
        @(posedge clk);
        cyc_n++;
        for (int i = 0; i < NDUT; i++) model_edge(i);
        #1;
        for (int i = 0; i < NDUT; i++) check_outputs(i);
    endtask

    task automatic wait_rnd(input int v, input int lim);
        int k;
        k = 0;
        while (!(it_en[0] && int'(rnd[0]) == v) && k < lim) begin
            step(); k++;
        end
        chk("wait_rnd", int'(it_en[0] && int'(rnd[0]) == v), 1);
    endtask

    task automatic wait_ov(input int lim);
        int k;
        k = 0;
        while (!out_vld[0] && k < lim) begin
            step(); k++;
        end
        chk("wait_out_vld", int'(out_vld[0]), 1);
    endtask

    task automatic start_job(input logic m);
        start_vld = 1'b1; mode_in = m;
        step();
        start_vld = 1'b0;
    endtask

    initial begin
        int it_cnt[NDUT];
        int last_ld[NDUT];
        int held;

        clr = 1'b1; start_vld = 1'b0; mode_in = 1'b0; abort = 1'b0; out_rdy = 1'b1;
        for (int i = 0; i < NDUT; i++) begin
            age[i] = -1; m_mode[i] = 1'b0; ridle[i] = 0;
        end
        repeat (3) step();
        clr = 1'b0;
        step();

        // Nominal job, mode latched while mode_in toggles
        for (int i = 0; i < NDUT; i++) it_cnt[i] = 0;
        start_job(1'b1);
        for (int k = 0; k < 25; k++) begin
            mode_in = ~mode_in;
            step();
            for (int i = 0; i < NDUT; i++) if (it_en[i]) it_cnt[i]++;
        end
        chk("it_en_count_n16", it_cnt[0], 16);
        chk("it_en_count_n1",  it_cnt[1], 1);

        // Backpressure: result held, start pulses ignored
        out_rdy = 1'b0;
        start_job(1'b0);
        wait_ov(40);
        held = 0;
        for (int k = 0; k < 10; k++) begin
            start_vld = k[0];
            step();
            if (out_vld[0]) held++;
        end
        start_vld = 1'b0;
        chk("held_out_vld", held, 10);
        out_rdy = 1'b1;
        repeat (3) step();

        // Abort mid-iteration, then a fresh job from round 0
        start_job(1'b1);
        wait_rnd(7, 40);
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        start_job(1'b0);
        wait_rnd(0, 5);
        repeat (25) step();

        // Reset mid-iteration
        start_job(1'b1);
        wait_rnd(5, 40);
        clr = 1'b1;
        repeat (3) step();
        clr = 1'b0;
        step();

        // Continuous start_vld: job spacing NROUNDS+3
        for (int i = 0; i < NDUT; i++) last_ld[i] = -1;
        start_vld = 1'b1;
        for (int k = 0; k < 80; k++) begin
            mode_in = 1'($urandom);
            step();
            for (int i = 0; i < NDUT; i++) begin
                if (ld[i]) begin
                    if (last_ld[i] >= 0) chk($sformatf("d%0d.spacing", i), cyc_n - last_ld[i], nr(i) + 3);
                    last_ld[i] = cyc_n;
                end
            end
        end
        start_vld = 1'b0;
        repeat (25) step();

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            start_vld = ($urandom_range(0, 1) == 1);
            mode_in   = 1'($urandom);
            abort     = ($urandom_range(0, 29) == 0);
            out_rdy   = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 199) == 0);
            step();
        end
        clr = 1'b0; abort = 1'b0; start_vld = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
